// File: rtl/lcd_bus_reader_if.sv
// Request/response handshake and LCD pin bundle for lcd_bus_reader.
// master: requester side (also presents the LCD data bus); slave: the reader.
interface lcd_bus_reader_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic       req_poll;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data_in;
    logic       bus_own;

    modport master (
        output req_valid, req_rs, req_poll, lcd_data_in,
        input  req_ready, rsp_valid, rsp_data, rsp_timeout,
        input  lcd_e, lcd_rs, lcd_rw, bus_own
    );

    modport slave (
        input  req_valid, req_rs, req_poll, lcd_data_in,
        output req_ready, rsp_valid, rsp_data, rsp_timeout,
        output lcd_e, lcd_rs, lcd_rw, bus_own
    );
endinterface

// File: rtl/lcd_bus_reader.sv
// HD44780 read engine: single register reads and busy-flag polls.
// Ports: clk, reset_n (async, active-low), bus (lcd_bus_reader_if.slave).
// Optional macro LCD_BUSY_TIMEOUT_EN adds a poll timeout of TIMEOUT_CYC cycles.
module lcd_bus_reader #(
    parameter int unsigned T_AS        = 2,
    parameter int unsigned T_EH        = 12,
    parameter int unsigned T_H         = 2,
    parameter int unsigned T_GAP       = 20,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    lcd_bus_reader_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, SETUP, EHIGH, HOLD, GAP, DONE
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rs_q, rs_d;
    logic        poll_q, poll_d;
    logic [7:0]  data_q, data_d;
    logic        e_q, lrs_q, rw_q, own_q, valid_q;
    logic        accept;
    logic        last;
    logic        busy_d;
    logic        tmo_hit;

    assign accept = bus.req_valid && (state_q == IDLE);
    assign last   = (cnt_q == 16'd0);
    assign busy_d = (state_d == SETUP) || (state_d == EHIGH) ||
                    (state_d == HOLD)  || (state_d == GAP);

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_data  = data_q;
    assign bus.lcd_e     = e_q;
    assign bus.lcd_rs    = lrs_q;
    assign bus.lcd_rw    = rw_q;
    assign bus.bus_own   = own_q;

    // Phase length minus one, loaded on entry and counted down to zero.
    function automatic logic [15:0] reload(state_e s);
        logic [15:0] r;
        r = 16'd0;
        unique case (s)
            SETUP:   r = 16'(T_AS - 1);
            EHIGH:   r = 16'(T_EH - 1);
            HOLD:    r = 16'(T_H - 1);
            GAP:     r = 16'(T_GAP - 1);
            default: r = 16'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        rs_d    = rs_q;
        poll_d  = poll_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    rs_d    = bus.req_rs & ~bus.req_poll;
                    poll_d  = bus.req_poll;
                end
            end
            SETUP: begin
                if (last) state_d = EHIGH;
            end
            EHIGH: begin
                // Only the final E-high cycle's bus value is captured.
                if (last) begin
                    state_d = HOLD;
                    data_d  = bus.lcd_data_in;
                end
            end
            HOLD: begin
                if (last) begin
                    if (poll_q && data_q[7] && !tmo_hit) state_d = GAP;
                    else                                 state_d = DONE;
                end
            end
            GAP: begin
                if (tmo_hit)   state_d = DONE;
                else if (last) state_d = SETUP;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d != state_q) cnt_d = reload(state_d);
        else if (!last)         cnt_d = cnt_q - 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            rs_q    <= 1'b0;
            poll_q  <= 1'b0;
            data_q  <= 8'h00;
            e_q     <= 1'b0;
            lrs_q   <= 1'b0;
            rw_q    <= 1'b0;
            own_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            poll_q  <= poll_d;
            data_q  <= data_d;
            // Outputs are registered from the next state so they line up
            // with the state they belong to.
            e_q     <= (state_d == EHIGH);
            lrs_q   <= busy_d & rs_d;
            rw_q    <= busy_d;
            own_q   <= busy_d;
            valid_q <= (state_d == DONE);
        end
    end

`ifdef LCD_BUSY_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_q;
    logic          to_q;
    logic          to_set;

    // Saturates at TIMEOUT_CYC; only polls can hit it.
    assign tmo_hit = poll_q && (tmo_q == TW'(TIMEOUT_CYC));
    // A poll that finishes with BF clear is not a timeout even if late.
    assign to_set  = tmo_hit &&
                     ((state_q == GAP) ||
                      ((state_q == HOLD) && last && data_q[7]));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
            to_q  <= 1'b0;
        end else if (accept) begin
            tmo_q <= '0;
            to_q  <= 1'b0;
        end else begin
            if (poll_q && !tmo_hit && (state_q != IDLE) && (state_q != DONE))
                tmo_q <= tmo_q + TW'(1);
            if (to_set)
                to_q <= 1'b1;
        end
    end

    assign bus.rsp_timeout = to_q;
`else
    assign tmo_hit         = (TIMEOUT_CYC == 0) & 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: doc/lcd_bus_reader.md
# lcd_bus_reader

Read-side HD44780 bus engine for the Yacht Dice board. It performs single register reads and busy-flag polls: it drives LCD_RW=1 and RS, pulses E with cycle-counted setup, width and hold, and samples the LCD data bus. It sits beside the LCD write path. The top-level pin arbiter gives it the LCD pins while `bus_own` is high, and the write sequencer uses it to wait on the busy flag instead of fixed delays.

## Interface
Parameters:
- `T_AS`, default 2: RS/RW setup cycles before E rises (minimum 1).
- `T_EH`, default 12: E-high cycles (minimum 1).
- `T_H`, default 2: hold cycles after E falls (minimum 1).
- `T_GAP`, default 20: idle cycles between successive poll reads (minimum 1).
- `TIMEOUT_CYC`, default 50000: poll timeout in cycles, counted from acceptance.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_rs`  in  1  RS for a single read: 0 = BF/AC, 1 = data RAM.
- `req_poll`  in  1  1 = poll BF until clear; `req_rs` is ignored and RS is forced to 0.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_data`  out  8  last sampled bus byte.
- `rsp_timeout`  out  1  qualifies `rsp_valid`: the poll ended by timeout.
- `lcd_e`, `lcd_rs`, `lcd_rw`  out  1 each  LCD control lines.
- `lcd_data_in`  in  8  LCD data bus, input side.
- `bus_own`  out  1  arbiter grant request; the data pins must be tri-stated while this is high.

## Operation
- States:
  - IDLE
  - SETUP (`T_AS` cycles, E=0)
  - EHIGH (`T_EH` cycles, E=1)
  - HOLD (`T_H` cycles, E=0)
  - GAP (`T_GAP` cycles, poll only)
  - DONE (1 cycle)
- `req_ready` = (state==IDLE). Acceptance happens on the rising edge where `req_valid` & `req_ready`; `req_rs` and `req_poll` are captured on that edge.
- `lcd_rw`=1 and `bus_own`=1 in SETUP, EHIGH, HOLD and GAP. Both are 0 in IDLE and DONE.
- `lcd_rs` holds the captured RS from SETUP through HOLD/GAP, and returns to 0 in IDLE.
- Sampling: `lcd_data_in` is registered into `rsp_data` on the edge that ends the last EHIGH cycle. Bus values at any other time are ignored.
- HOLD exit:
  - Single read → DONE.
  - Poll with sampled bit 7 = 0 → DONE.
  - Poll with sampled bit 7 = 1 → GAP, then SETUP.
- In DONE, `rsp_valid`=1; the next state is IDLE.
- `rsp_data` holds its value until the next sample. `rsp_timeout` is cleared on acceptance.
- A single 16-bit phase counter is reloaded on every state entry.
- Registered outputs; reset values: `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `bus_own`=0, `rsp_valid`=0, `rsp_data`=8'h00, `rsp_timeout`=0. After reset the state is IDLE, so `req_ready`=1.
- Reset mid-transaction: all outputs go to reset values asynchronously, including dropping `lcd_e`. No response is produced.

## Timing
- Acceptance edge = cycle 0:
  - SETUP spans cycles 1..T_AS.
  - EHIGH spans T_AS+1..T_AS+T_EH.
  - HOLD spans the following T_H cycles.
  - `rsp_valid` is high in cycle T_AS+T_EH+T_H+1. With defaults this is cycle 17.
- Poll period per read = T_AS+T_EH+T_H+T_GAP cycles (36 with defaults). E pulses are exactly `T_EH` cycles wide.
- A request held high is re-accepted in the first IDLE cycle after DONE. The minimum request-to-request spacing is T_AS+T_EH+T_H+2 cycles.
- `req_ready` is low from the cycle after acceptance through DONE.

## Configuration
- `LCD_BUSY_TIMEOUT_EN` defined:
  - A timeout counter of width $clog2(TIMEOUT_CYC+1) runs from acceptance during polls.
  - When it reaches `TIMEOUT_CYC`, any in-progress E pulse completes through HOLD. GAP is skipped and the FSM goes to DONE with `rsp_timeout`=1 and `rsp_data` = the last sample.
  - Single reads never time out.
- Not defined: no counter is built, polls continue indefinitely, and `rsp_timeout` is tied to 0.

## Test plan
- Single read: `req_rs`=1, `lcd_data_in`=8'h5A → `lcd_rs`=1, `lcd_rw`=1, `lcd_e` high for exactly 12 cycles, `rsp_valid` at cycle 17, `rsp_data`=8'h5A, `rsp_timeout`=0.
- Poll: bus reads 8'h80 for three pulses, then 8'h07 → four E pulses 36 cycles apart, `lcd_rs`=0 throughout, `rsp_data`=8'h07, `rsp_timeout`=0.
- Timeout (macro defined, `TIMEOUT_CYC`=200): bus stuck at 8'hC3 → `rsp_timeout`=1, `rsp_data`=8'hC3, no E pulse after `rsp_valid`. Same stimulus with the macro undefined → no response within 2000 cycles.
- Back-to-back: `req_valid` held high → second acceptance in the cycle after DONE, `req_ready` low in between, `bus_own` low for exactly DONE plus one IDLE cycle.
- Reset asserted in the 5th EHIGH cycle → `lcd_e`, `lcd_rw` and `bus_own` low before the next edge. After release: `req_ready`=1, no `rsp_valid`.
- Sample window: `lcd_data_in` toggles to 8'hFF everywhere except the final EHIGH cycle (8'h21) → `rsp_data`=8'h21.
